rf_alu_gen: RTL and testbench

RF_ALU_GEN -- requirements
Module: rf_alu_gen

---
 rtl/rf_alu_pkg.sv | 54 +++++
 rtl/alu_gen.sv | 92 +++++++++
 rtl/rf_alu_gen.sv | 143 ++++++++++++++
 tb/tb_rf_alu_gen.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_alu_pkg.sv
// Shared encodings for the register-file / ALU datapath: ALU operation
// codes, write-back source select, the PSW flag bundle and small helpers.
package rf_alu_pkg;

   // ALU operation select; codes 11..15 are unassigned and act as PASSA
   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_ADC   = 4'd1,
      ALU_SUB   = 4'd2,
      ALU_SBB   = 4'd3,
      ALU_AND   = 4'd4,
      ALU_OR    = 4'd5,
      ALU_XOR   = 4'd6,
      ALU_PASSA = 4'd7,
      ALU_SHL   = 4'd8,
      ALU_SHR   = 4'd9,
      ALU_SAR   = 4'd10
   } alu_op_e;

   // Write-back source select; WB_NONE blocks the register-file write
   typedef enum logic [1:0] {
      WB_MEM  = 2'b00,
      WB_RES  = 2'b01,
      WB_IL   = 2'b10,
      WB_NONE = 2'b11
   } wb_sel_e;

   // Register index width carried in the instruction fields
   localparam int REG_AW = 3;

   // Processor status word, packed in the order the flags are exported
   typedef struct packed {
      logic c;
      logic z;
      logic n;
      logic v;
   } psw_t;

   // A register-file write happens only when enabled and a real source is chosen
   function automatic logic wb_writes(input logic wbrf, input logic [1:0] sel);
      return wbrf && (sel != WB_NONE);
   endfunction

   // Signed overflow of a + b, from the operand and result sign bits
   function automatic logic ovf_add(input logic a_s, input logic b_s, input logic r_s);
      return (a_s == b_s) && (r_s != a_s);
   endfunction

   // Signed overflow of a - b, from the operand and result sign bits
   function automatic logic ovf_sub(input logic a_s, input logic b_s, input logic r_s);
      return (a_s != b_s) && (r_s != a_s);
   endfunction

endpackage

// File: rtl/alu_gen.sv
// Purely combinational ALU: arithmetic with carry/borrow, logic ops,
// pass-through and three shifts. Flags are derived from the result here;
// the caller decides whether to register them.
module alu_gen
   import rf_alu_pkg::*;
#(
   parameter int DW = 16
) (
   input  logic [DW-1:0] A,
   input  logic [DW-1:0] B,
   input  logic          Cin,
   input  logic [3:0]    ALUop,
   output logic [DW-1:0] Sum,
   output logic          C,
   output logic          Z,
   output logic          N,
   output logic          V
);

   localparam int SW = $clog2(DW);

   logic [SW-1:0] amt;
   logic [DW:0]   wide;
   logic [DW-1:0] r;
   logic          c;
   logic          v;

   // Shift amount is the low bits of B; larger values wrap
   assign amt = B[SW-1:0];

   // Operation decode; shifts run one bit wider so the bit shifted out lands
   // in a fixed position and a zero shift yields carry 0 with no special case
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
      wide = '0;
      r    = A;
      c    = 1'b0;
      v    = 1'b0;
      case (ALUop)
         ALU_ADD: begin
            wide = {1'b0, A} + {1'b0, B};
            r    = wide[DW-1:0];
            c    = wide[DW];
            v    = ovf_add(A[DW-1], B[DW-1], r[DW-1]);
         end
         ALU_ADC: begin
            wide = {1'b0, A} + {1'b0, B} + {{DW{1'b0}}, Cin};
            r    = wide[DW-1:0];
            c    = wide[DW];
            v    = ovf_add(A[DW-1], B[DW-1], r[DW-1]);
         end
         ALU_SUB: begin
            wide = {1'b0, A} - {1'b0, B};
            r    = wide[DW-1:0];
            c    = wide[DW];
            v    = ovf_sub(A[DW-1], B[DW-1], r[DW-1]);
         end
         ALU_SBB: begin
            wide = {1'b0, A} - {1'b0, B} - {{DW{1'b0}}, Cin};
            r    = wide[DW-1:0];
            c    = wide[DW];
            v    = ovf_sub(A[DW-1], B[DW-1], r[DW-1]);
         end
         ALU_AND: r = A & B;
         ALU_OR:  r = A | B;
         ALU_XOR: r = A ^ B;
         ALU_SHL: begin
            wide = {1'b0, A} << amt;
            r    = wide[DW-1:0];
            c    = wide[DW];
         end
         ALU_SHR: begin
            wide = {A, 1'b0} >> amt;
            r    = wide[DW:1];
            c    = wide[0];
         end
         ALU_SAR: begin
            wide = $signed({A, 1'b0}) >>> amt;
            r    = wide[DW:1];
            c    = wide[0];
         end
         default: r = A;
      endcase
   end

   assign Sum = r;
   assign C   = c;
   assign V   = v;
   assign Z   = ~|r;
   assign N   = r[DW-1];

endmodule

// File: rtl/rf_alu_gen.sv
// Register file with write-first bypass, ID/EXE operand buffers, result
// register and PSW around the alu_gen datapath. Write-back target is always
// rd; the ALU sees the buffered operands and the registered carry.
module rf_alu_gen
   import rf_alu_pkg::*;
#(
   parameter int DW   = 16,
   parameter int NREG = 8
) (
   input  logic          clk,
   input  logic          Reset,
   input  logic [15:0]   Ins,
   input  logic [DW-1:0] WBData,
   input  logic          WBRF,
   input  logic [1:0]    WBsel,
   input  logic          RBresource,
   input  logic          OprandB,
   input  logic          LI,
   input  logic          Buff_IDEXE,
   input  logic          Buff_EXEWB,
   input  logic [3:0]    ALUop,
   input  logic          FlagWE,
   output logic [DW-1:0] Sum,
   output logic [DW-1:0] Res,
   output logic [DW-1:0] IL_EXE,
   output logic [DW-1:0] StoreData,
   output logic [DW-1:0] OutR,
   output logic          C,
   output logic          Z,
   output logic          N,
   output logic          V
);

   // Instruction fields (imm5 overlaps rn, imm8 overlaps rm/rn)
   logic [REG_AW-1:0] rd;
   logic [REG_AW-1:0] rm;
   logic [REG_AW-1:0] rn;
   logic [REG_AW-1:0] rb_addr;
   logic [4:0]        imm5;
   logic [7:0]        imm8;
   logic              unused_ins;

   assign rd         = Ins[10:8];
   assign rm         = Ins[7:5];
   assign rn         = Ins[4:2];
   assign imm5       = Ins[4:0];
   assign imm8       = Ins[7:0];
   assign unused_ins = ^Ins[15:11];
   assign rb_addr    = RBresource ? rd : rn;

   logic [DW-1:0] rf [NREG];
   logic [DW-1:0] wb_val;
   logic          wb_en;
   logic [DW-1:0] rd_a;
   logic [DW-1:0] rd_b;
   logic [DW-1:0] b_src;
   logic [DW-1:0] il_src;
   logic [DW-1:0] b_buf;
   psw_t          psw;
   psw_t          alu_flags;
   logic          alu_c;
   logic          alu_z;
   logic          alu_n;
   logic          alu_v;

   // Write-back source mux; the reserved select is masked off by wb_en
   always_comb begin
      case (WBsel)
         WB_RES:  wb_val = Res;
         WB_IL:   wb_val = IL_EXE;
         default: wb_val = WBData;
      endcase
   end

   assign wb_en = wb_writes(WBRF, WBsel);

   // Read ports forward a same-cycle write so a buffer load sees the new value
   assign rd_a = (wb_en && (rd == rm))      ? wb_val : rf[rm];
   assign rd_b = (wb_en && (rd == rb_addr)) ? wb_val : rf[rb_addr];

   // ALU B operand and load-immediate forms (LLI zero-extends, LHI keeps low bits)
   assign b_src  = OprandB ? {{(DW-5){1'b0}}, imm5} : rd_b;
   assign il_src = LI ? {{(DW-8){1'b0}}, imm8} : {imm8, rd_b[DW-9:0]};

   // Register file write on rd; cleared as a whole by reset
   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         // NOTE: the register file is flops, not a RAM macro, because reset must clear every entry asynchronously.
         for (int i = 0; i < NREG; i++) rf[i] <= '0;
      end else if (wb_en) begin
         // NOTE: state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
         rf[rd] <= wb_val;
      end
   end

   // ID/EXE operand buffers, loaded together and held otherwise
   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         OutR      <= '0;
         b_buf     <= '0;
         StoreData <= '0;
         IL_EXE    <= '0;
      end else if (Buff_IDEXE) begin
         OutR      <= rd_a;
         b_buf     <= b_src;
         StoreData <= rd_b;
         IL_EXE    <= il_src;
      end
   end

   alu_gen #(
      .DW(DW)
   ) u_alu (
      .A     (OutR),
      .B     (b_buf),
      .Cin   (psw.c),
      .ALUop (ALUop),
      .Sum   (Sum),
      .C     (alu_c),
      .Z     (alu_z),
      .N     (alu_n),
      .V     (alu_v)
   );

   assign alu_flags = {alu_c, alu_z, alu_n, alu_v};

   // Result register and PSW; flags move only together with a result load
   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         Res <= '0;
         psw <= '0;
      end else if (Buff_EXEWB) begin
         Res <= Sum;
         if (FlagWE) psw <= alu_flags;
      end
   end

   assign C = psw.c;
   assign Z = psw.z;
   assign N = psw.n;
   assign V = psw.v;

endmodule

// File: tb/tb_rf_alu_gen.sv
// Self-checking bench for rf_alu_gen (DW=16): directed scenarios plus
// random control/data streams compared against a behavioural model.
module tb_rf_alu_gen;

   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          Reset;
   logic [15:0]   Ins;
   logic [DW-1:0] WBData;
   logic          WBRF;
   logic [1:0]    WBsel;
   logic          RBresource;
   logic          OprandB;
   logic          LI;
   logic          Buff_IDEXE;
   logic          Buff_EXEWB;
   logic [3:0]    ALUop;
   logic          FlagWE;
   logic [DW-1:0] Sum;
   logic [DW-1:0] Res;
   logic [DW-1:0] IL_EXE;
   logic [DW-1:0] StoreData;
   logic [DW-1:0] OutR;
   logic          C;
   logic          Z;
   logic          N;
   logic          V;

   rf_alu_gen #(.DW(DW), .NREG(8)) dut (
      .clk        (clk),
      .Reset      (Reset),
      .Ins        (Ins),
      .WBData     (WBData),
      .WBRF       (WBRF),
      .WBsel      (WBsel),
      .RBresource (RBresource),
      .OprandB    (OprandB),
      .LI         (LI),
      .Buff_IDEXE (Buff_IDEXE),
      .Buff_EXEWB (Buff_EXEWB),
      .ALUop      (ALUop),
      .FlagWE     (FlagWE),
      .Sum        (Sum),
      .Res        (Res),
      .IL_EXE     (IL_EXE),
      .StoreData  (StoreData),
      .OutR       (OutR),
      .C          (C),
      .Z          (Z),
      .N          (N),
      .V          (V)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Model state
   logic [15:0] m_rf [8];
   logic [15:0] m_outr;
   logic [15:0] m_b;
   logic [15:0] m_sd;
   logic [15:0] m_il;
   logic [15:0] m_res;
   logic [3:0]  m_psw;   // {C,Z,N,V}

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Reference ALU in plain integer arithmetic; returns {C,Z,N,V,result}
   function automatic logic [19:0] alu_ref(input int a, input int b, input int cin, input int op);
      int r, c, v, sa, sb, sr, full, amt;
      logic [19:0] ret;
      r = a; c = 0; v = 0;
      sa  = (a >= 32768) ? a - 65536 : a;
      sb  = (b >= 32768) ? b - 65536 : b;
      amt = b % 16;
      case (op)
         0: begin full = a + b;        c = (full >> 16) & 1; sr = sa + sb;       v = (sr > 32767 || sr < -32768) ? 1 : 0; r = full & 'hFFFF; end
         1: begin full = a + b + cin;  c = (full >> 16) & 1; sr = sa + sb + cin; v = (sr > 32767 || sr < -32768) ? 1 : 0; r = full & 'hFFFF; end
         2: begin full = a - b;        c = (a < b) ? 1 : 0;       sr = sa - sb;       v = (sr > 32767 || sr < -32768) ? 1 : 0; r = full & 'hFFFF; end
         3: begin full = a - b - cin;  c = (a < b + cin) ? 1 : 0; sr = sa - sb - cin; v = (sr > 32767 || sr < -32768) ? 1 : 0; r = full & 'hFFFF; end
         4: r = a & b;
         5: r = a | b;
         6: r = a ^ b;
         8: begin r = (a << amt) & 'hFFFF; c = (amt == 0) ? 0 : (a >> (16 - amt)) & 1; end
         9: begin r = a >> amt;            c = (amt == 0) ? 0 : (a >> (amt - 1)) & 1; end
         10: begin r = (sa >>> amt) & 'hFFFF; c = (amt == 0) ? 0 : (a >> (amt - 1)) & 1; end
         default: r = a;
      endcase
      ret = {c[0], (r == 0) ? 1'b1 : 1'b0, r[15], v[0], r[15:0]};
      return ret;
   endfunction

   task automatic clear_inputs();
      Ins = '0; WBData = '0; WBRF = 0; WBsel = 2'b00; RBresource = 0; OprandB = 0;
      LI = 0; Buff_IDEXE = 0; Buff_EXEWB = 0; ALUop = '0; FlagWE = 0;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_rf[i] = '0;
      m_outr = '0; m_b = '0; m_sd = '0; m_il = '0; m_res = '0; m_psw = '0;
   endtask

   task automatic check_all();
      logic [19:0] e;
      e = alu_ref(int'(m_outr), int'(m_b), int'(m_psw[3]), int'(ALUop));
      check("OutR", OutR, m_outr);
      check("StoreData", StoreData, m_sd);
      check("IL_EXE", IL_EXE, m_il);
      check("Res", Res, m_res);
      check("PSW", {C, Z, N, V}, m_psw);
      check("Sum", Sum, e[15:0]);
   endtask

   // One clock edge: model next state from current inputs, then compare
   task automatic tick();
      logic [2:0]  rd, rm, rbs;
      logic [15:0] wbv, ra, rb, il, bsrc;
      logic        wen;
      logic [19:0] e;
      rd  = Ins[10:8];
      rm  = Ins[7:5];
      rbs = RBresource ? Ins[10:8] : Ins[4:2];
      case (WBsel)
         2'b00:   wbv = WBData;
         2'b01:   wbv = m_res;
         2'b10:   wbv = m_il;
         default: wbv = '0;
      endcase
      wen  = WBRF && (WBsel != 2'b11);
      ra   = (wen && rd == rm)  ? wbv : m_rf[rm];
      rb   = (wen && rd == rbs) ? wbv : m_rf[rbs];
      il   = LI ? {8'h00, Ins[7:0]} : {Ins[7:0], rb[7:0]};
      bsrc = OprandB ? {11'b0, Ins[4:0]} : rb;
      e    = alu_ref(int'(m_outr), int'(m_b), int'(m_psw[3]), int'(ALUop));
      @(posedge clk);
      #1;
      if (Buff_IDEXE) begin m_outr = ra; m_b = bsrc; m_sd = rb; m_il = il; end
      if (Buff_EXEWB) begin m_res = e[15:0]; if (FlagWE) m_psw = e[19:16]; end
      if (wen) m_rf[rd] = wbv;
      check_all();
   endtask

   task automatic do_wr(input int r, input logic [15:0] val);
      clear_inputs();
      Ins = {5'b0, 3'(r), 8'h00}; WBData = val; WBRF = 1; WBsel = 2'b00;
      tick();
   endtask

   task automatic do_ld(input int rm, input int rn);
      clear_inputs();
      Ins = {5'b0, 3'd0, 3'(rm), 3'(rn), 2'b00}; Buff_IDEXE = 1;
      tick();
   endtask

   task automatic do_ex(input logic [3:0] op);
      clear_inputs();
      ALUop = op; Buff_EXEWB = 1; FlagWE = 1;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   initial begin
      clear_inputs();
      model_reset();
      Reset = 0;
      #12;
      check_all();
      Reset = 1;

      // ADD with carry-out to zero, then ADC consuming the carry
      do_wr(1, 16'hFFFF); do_wr(2, 16'h0001);
      do_ld(1, 2); do_ex(4'd0);
      check("add_res", Res, 16'h0000);
      check("add_psw", {C, Z, N, V}, 4'b1100);
      do_ld(2, 2); do_ex(4'd1);
      check("adc_res", Res, 16'h0003);

      // SUB overflow, borrow, then SBB using the borrow
      do_wr(1, 16'h8000); do_wr(2, 16'h0001);
      do_ld(1, 2); do_ex(4'd2);
      check("sub_res", Res, 16'h7FFF);
      check("sub_psw", {C, Z, N, V}, 4'b0001);
      do_ld(2, 1); do_ex(4'd2);
      check("sub_borrow", C, 1'b1);
      do_ld(1, 2); do_ex(4'd3);
      check("sbb_res", Res, 16'h7FFE);

      // LHI into R3 via IL_EXE write-back
      do_wr(3, 16'h1234);
      clear_inputs(); Ins = {5'b0, 3'd3, 8'hAB}; RBresource = 1; LI = 0; Buff_IDEXE = 1; tick();
      check("lhi_il", IL_EXE, 16'hAB34);
      clear_inputs(); Ins = {5'b0, 3'd3, 8'h00}; WBRF = 1; WBsel = 2'b10; tick();
      do_ld(3, 0);
      check("lhi_r3", OutR, 16'hAB34);

      // LLI zero-extends imm8
      clear_inputs(); Ins = {5'b0, 3'd0, 8'hC3}; LI = 1; Buff_IDEXE = 1; tick();
      check("lli_il", IL_EXE, 16'h00C3);

      // Same-edge write and buffer load sees the new value
      clear_inputs(); Ins = {5'b0, 3'd5, 3'd5, 3'd0, 2'b00}; WBRF = 1; WBData = 16'h5A5A; Buff_IDEXE = 1; tick();
      check("bypass_outr", OutR, 16'h5A5A);

      // Reserved write-back select suppresses the write
      clear_inputs(); Ins = {5'b0, 3'd6, 8'h00}; WBRF = 1; WBsel = 2'b11; WBData = 16'hFFFF; tick();
      do_ld(6, 6);
      check("wbsel11_r6", OutR, 16'h0000);

      // Shifts by imm5=1
      do_wr(4, 16'h8001);
      clear_inputs(); Ins = {5'b0, 3'd0, 3'd4, 5'd1}; OprandB = 1; Buff_IDEXE = 1; tick();
      do_ex(4'd8);
      check("shl_res", Res, 16'h0002);
      check("shl_c", C, 1'b1);
      do_ex(4'd10);
      check("sar_res", Res, 16'hC000);
      check("sar_c", C, 1'b1);

      // Pipeline advance: load and execute on the same edge
      clear_inputs(); Ins = {5'b0, 3'd0, 3'd2, 3'd1, 2'b00}; Buff_IDEXE = 1; Buff_EXEWB = 1; ALUop = 4'd0; tick();

      // Random stream against the model
      for (int i = 0; i < 400; i++) begin
         Ins        = 16'($urandom);
         WBData     = 16'($urandom);
         WBRF       = 1'($urandom_range(0, 1));
         WBsel      = 2'($urandom_range(0, 3));
         RBresource = 1'($urandom_range(0, 1));
         OprandB    = 1'($urandom_range(0, 1));
         LI         = 1'($urandom_range(0, 1));
         Buff_IDEXE = 1'($urandom_range(0, 1));
         Buff_EXEWB = 1'($urandom_range(0, 1));
         ALUop      = 4'($urandom_range(0, 15));
         FlagWE     = 1'($urandom_range(0, 1));
         tick();
      end

      // Asynchronous reset mid-cycle clears everything before any edge
      do_wr(7, 16'h00FF);
      #2;
      Reset = 0;
      #1;
      model_reset();
      check("rst_outr", OutR, 16'h0000);
      check("rst_sd", StoreData, 16'h0000);
      check("rst_il", IL_EXE, 16'h0000);
      check("rst_res", Res, 16'h0000);
      check("rst_sum", Sum, 16'h0000);
      check("rst_psw", {C, Z, N, V}, 4'b0000);

      // Edges while in reset must not write
      clear_inputs(); Ins = {5'b0, 3'd7, 8'h00}; WBRF = 1; WBData = 16'h1111;
      repeat (2) @(posedge clk);
      #2;
      Reset = 1;
      do_ld(7, 7);
      check("rst_r7", OutR, 16'h0000);
      do_wr(7, 16'h2222);
      do_ld(7, 7);
      check("post_rst_r7", OutR, 16'h2222);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
